// File: rtl/data_streamer.sv
// Sequential reader for a small combinational byte store: walks indices 0..DEPTH-1
// on start and offers each byte on a valid/ready stream with last flag and running checksum.
module data_streamer #(
  parameter int DEPTH       = 11,
  parameter int INDEX_WIDTH = 4,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic [INDEX_WIDTH-1:0] data_index,
  input  logic [DATA_WIDTH-1:0]  data_in,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done,
  output logic [DATA_WIDTH-1:0]  checksum
);

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

  state_t                 state, state_nxt;
  logic [INDEX_WIDTH-1:0] idx;
  logic                   xfer;
  logic                   at_last;

  assign xfer       = (state == SEND) && out_valid && out_ready;
  assign at_last    = (idx == LAST_IDX);
  // idx returns to 0 whenever the FSM goes idle, so the store index is pure register state
  assign data_index = idx;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   state_nxt = SEND;
      SEND:    if (xfer) state_nxt = at_last ? IDLE : FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      checksum  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            idx      <= '0;
            checksum <= '0;
          end
        end
        FETCH: begin
          out_data  <= data_in;
          out_valid <= 1'b1;
          out_last  <= at_last;
        end
        SEND: begin
          if (xfer) begin
            checksum  <= checksum + out_data;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (at_last) begin
              idx  <= '0;
              done <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
